// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit: bus handshake FSM, lane alignment and MEM/WB register
module mem_stage_lsu #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  // EX/MEM pipeline fields
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic [1:0]        ResultSrcM,
  input  logic [2:0]        funct3M,
  input  logic [XLEN-1:0]   ALUResultM,
  input  logic [XLEN-1:0]   WriteDataM,
  input  logic [REG_AW-1:0] RdM,
  input  logic [XLEN-1:0]   PCPlus4M,
  // data bus request channel
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [XLEN-1:0]   req_addr,
  output logic [XLEN-1:0]   req_wdata,
  output logic [3:0]        req_be,
  // data bus response channel
  input  logic              rsp_valid,
  input  logic [XLEN-1:0]   rsp_rdata,
  // pipeline control
  output logic              stall_o,
  output logic              misalign_o,
  // MEM/WB pipeline register
  output logic              RegWriteW,
  output logic [1:0]        ResultSrcW,
  output logic [XLEN-1:0]   ReadDataW,
  output logic [XLEN-1:0]   ALUResultW,
  output logic [REG_AW-1:0] RdW,
  output logic [XLEN-1:0]   PCPlus4W
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state, state_next;

  logic       is_load;
  logic       mem_op;
  logic       size_b;
  logic       size_h;
  logic       size_w;
  logic       misaligned;
  logic [1:0] lane;

  // Classify the access: byte/half by funct3[1:0], every other encoding behaves as a word
  always_comb begin
    lane       = ALUResultM[1:0];
    is_load    = (ResultSrcM == 2'b01);
    mem_op     = MemWriteM | is_load;
    size_b     = (funct3M[1:0] == 2'b00);
    size_h     = (funct3M[1:0] == 2'b01);
    size_w     = !size_b && !size_h;
    misaligned = mem_op & ((size_h & lane[0]) | (size_w & (lane != 2'b00)));
  end

  // Request fields follow EX/MEM directly; the stall keeps them steady for the whole handshake
  always_comb begin
    req_addr  = {ALUResultM[XLEN-1:2], 2'b00};
    req_we    = MemWriteM;
    req_be    = 4'b1111;
    req_wdata = WriteDataM;
    if (size_b) begin
      req_be    = 4'b0001 << lane;
      req_wdata = {4{WriteDataM[7:0]}};
    end else if (size_h) begin
      req_be    = 4'b0011 << {lane[1], 1'b0};
      req_wdata = {2{WriteDataM[15:0]}};
    end
  end

  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_data;

  // Pick the addressed lane out of the read word and extend it; funct3[2] selects zero-extension
  always_comb begin
    case (lane)
      2'd0:    byte_sel = rsp_rdata[7:0];
      2'd1:    byte_sel = rsp_rdata[15:8];
      2'd2:    byte_sel = rsp_rdata[23:16];
      default: byte_sel = rsp_rdata[31:24];
    endcase
    half_sel = lane[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];
    if (size_b)
      load_data = {{24{~funct3M[2] & byte_sel[7]}}, byte_sel};
    else if (size_h)
      load_data = {{16{~funct3M[2] & half_sel[15]}}, half_sel};
    else
      load_data = rsp_rdata;
  end

  // Bus FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Bus FSM next state, handshake and stall generation
  always_comb begin
    state_next = state;
    req_valid  = 1'b0;
    stall_o    = 1'b0;
    misalign_o = 1'b0;
    case (state)
      IDLE: begin
        if (misaligned) begin
          misalign_o = 1'b1;
        end else if (mem_op) begin
          req_valid  = 1'b1;
          stall_o    = 1'b1;
          state_next = req_ready ? WAIT : REQ;
        end
      end
      REQ: begin
        req_valid = 1'b1;
        stall_o   = 1'b1;
        if (req_ready)
          state_next = WAIT;
      end
      WAIT: begin
        if (rsp_valid)
          state_next = IDLE;
        else
          stall_o = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  logic retire_load;

  // Read data is only captured when a load's response completes; stores ignore rsp_rdata
  always_comb begin
    retire_load = (state == WAIT) & rsp_valid & is_load & ~MemWriteM;
  end

  // MEM/WB register: advance when not stalled, otherwise inject a bubble and hold the rest
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      ReadDataW  <= '0;
      ALUResultW <= '0;
      RdW        <= '0;
      PCPlus4W   <= '0;
    end else if (stall_o) begin
      RegWriteW <= 1'b0;
    end else begin
      RegWriteW  <= RegWriteM & ~misalign_o;
      ResultSrcW <= ResultSrcM;
      ALUResultW <= ALUResultM;
      RdW        <= RdM;
      PCPlus4W   <= PCPlus4M;
      if (retire_load)
        ReadDataW <= load_data;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;

  logic        clk;
  logic        reset;
  logic        RegWriteM;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [4:0]  RdM;
  logic [31:0] PCPlus4M;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        stall_o;
  logic        misalign_o;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ReadDataW;
  logic [31:0] ALUResultW;
  logic [4:0]  RdW;
  logic [31:0] PCPlus4W;

  int vectors;
  int miscompares;
  int stall_cnt;
  int retire_cnt;

  mem_stage_lsu #(.XLEN(32), .REG_AW(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .funct3M    (funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .RdM        (RdM),
    .PCPlus4M   (PCPlus4M),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .stall_o    (stall_o),
    .misalign_o (misalign_o),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .ReadDataW  (ReadDataW),
    .ALUResultW (ALUResultW),
    .RdW        (RdW),
    .PCPlus4W   (PCPlus4W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic mw, input logic [1:0] rs, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                       input logic [31:0] pc4);
    RegWriteM  = rw;
    MemWriteM  = mw;
    ResultSrcM = rs;
    funct3M    = f3;
    ALUResultM = addr;
    WriteDataM = wd;
    RdM        = rd;
    PCPlus4M   = pc4;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0);
  endtask

  // Zero-wait load: issue with req_ready high, respond on the next cycle, return once MEM/WB is loaded
  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b01, f3, addr, 32'h0, 5'd9, 32'h0);
    req_ready = 1'b1;
    rsp_valid = 1'b0;
    @(negedge clk);
    rsp_valid = 1'b1;
    rsp_rdata = rdata;
    @(negedge clk);
    rsp_valid = 1'b0;
    req_ready = 1'b0;
    nop();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_rdata   = 32'h0;
    nop();
    repeat (2) @(posedge clk);

    // reset state
    @(negedge clk);
    chk("rst_regwrite", RegWriteW, 1'b0);
    chk("rst_readdata", ReadDataW, 32'h0);
    chk("rst_aluresult", ALUResultW, 32'h0);
    chk("rst_req_valid", req_valid, 1'b0);
    chk("rst_stall", stall_o, 1'b0);
    chk("rst_misalign", misalign_o, 1'b0);
    reset = 1'b0;

    // lw 0x100, ready at once, response the following cycle
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b01, 3'b010, 32'h100, 32'h0, 5'd5, 32'h204);
    req_ready = 1'b1;
    #1;
    chk("lw_req_valid", req_valid, 1'b1);
    chk("lw_stall", stall_o, 1'b1);
    chk("lw_be", req_be, 4'b1111);
    chk("lw_addr", req_addr, 32'h100);
    chk("lw_we", req_we, 1'b0);
    @(negedge clk);
    chk("lw_bubble", RegWriteW, 1'b0);
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_rdata = 32'hDEADBEEF;
    #1;
    chk("lw_wait_valid", req_valid, 1'b0);
    chk("lw_rsp_stall", stall_o, 1'b0);
    @(negedge clk);
    rsp_valid = 1'b0;
    chk("lw_readdata", ReadDataW, 32'hDEADBEEF);
    chk("lw_regwrite", RegWriteW, 1'b1);
    chk("lw_rd", RdW, 5'd5);
    chk("lw_resultsrc", ResultSrcW, 2'b01);
    chk("lw_pc4", PCPlus4W, 32'h204);
    nop();

    // sub-word loads from 0x80112233
    do_load(3'b000, 32'h103, 32'h80112233);
    chk("lb_103", ReadDataW, 32'hFFFFFF80);
    do_load(3'b100, 32'h103, 32'h80112233);
    chk("lbu_103", ReadDataW, 32'h00000080);
    do_load(3'b000, 32'h101, 32'h80112233);
    chk("lb_101", ReadDataW, 32'h00000022);
    do_load(3'b001, 32'h102, 32'h80112233);
    chk("lh_102", ReadDataW, 32'hFFFF8011);
    do_load(3'b101, 32'h100, 32'h80112233);
    chk("lhu_100", ReadDataW, 32'h00002233);
    do_load(3'b111, 32'h104, 32'h80112233);
    chk("undef_f3_word", ReadDataW, 32'h80112233);

    // sh 0x102: upper half lanes, data replicated; read data must not change
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b00, 3'b001, 32'h102, 32'h1234ABCD, 5'd0, 32'h0);
    req_ready = 1'b1;
    #1;
    chk("sh_we", req_we, 1'b1);
    chk("sh_be", req_be, 4'b1100);
    chk("sh_wdata", req_wdata, 32'hABCDABCD);
    chk("sh_addr", req_addr, 32'h100);
    @(negedge clk);
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_rdata = 32'h55555555;
    #1;
    chk("sh_ack_stall", stall_o, 1'b0);
    @(negedge clk);
    rsp_valid = 1'b0;
    chk("sh_readdata_held", ReadDataW, 32'h80112233);
    chk("sh_regwrite", RegWriteW, 1'b0);
    nop();

    // sb 0x101
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b00, 3'b000, 32'h101, 32'h000000A5, 5'd0, 32'h0);
    #1;
    chk("sb_be", req_be, 4'b0010);
    chk("sb_wdata", req_wdata, 32'hA5A5A5A5);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    @(negedge clk);
    rsp_valid = 1'b0;
    nop();

    // back-pressure: ready low 3 cycles, response on the second WAIT cycle
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b01, 3'b010, 32'h200, 32'h0, 5'd7, 32'h0);
    req_ready  = 1'b0;
    stall_cnt  = 0;
    retire_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_valid", req_valid, 1'b1);
      chk("bp_addr", req_addr, 32'h200);
      chk("bp_be", req_be, 4'b1111);
      stall_cnt += int'(stall_o);
      @(negedge clk);
      retire_cnt += int'(RegWriteW);
    end
    req_ready = 1'b1;
    #1;
    chk("bp_accept_valid", req_valid, 1'b1);
    stall_cnt += int'(stall_o);
    @(negedge clk);
    retire_cnt += int'(RegWriteW);
    req_ready = 1'b0;
    #1;
    chk("bp_wait_valid", req_valid, 1'b0);
    stall_cnt += int'(stall_o);
    @(negedge clk);
    retire_cnt += int'(RegWriteW);
    rsp_valid = 1'b1;
    rsp_rdata = 32'h0BADF00D;
    #1;
    stall_cnt += int'(stall_o);
    @(negedge clk);
    retire_cnt += int'(RegWriteW);
    rsp_valid = 1'b0;
    chk("bp_readdata", ReadDataW, 32'h0BADF00D);
    chk("bp_rd", RdW, 5'd7);
    nop();
    @(negedge clk);
    retire_cnt += int'(RegWriteW);
    chk("bp_stall_cycles", stall_cnt, 32'd5);
    chk("bp_retires", retire_cnt, 32'd1);

    // misaligned lw 0x102: flag, no request, bubble
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b01, 3'b010, 32'h102, 32'h0, 5'd4, 32'h0);
    req_ready = 1'b1;
    #1;
    chk("mis_flag", misalign_o, 1'b1);
    chk("mis_req_valid", req_valid, 1'b0);
    chk("mis_stall", stall_o, 1'b0);
    @(negedge clk);
    chk("mis_regwrite", RegWriteW, 1'b0);
    drive(1'b0, 1'b1, 2'b00, 3'b001, 32'h101, 32'h0, 5'd0, 32'h0);
    #1;
    chk("mis_sh_flag", misalign_o, 1'b1);
    chk("mis_sh_req_valid", req_valid, 1'b0);
    req_ready = 1'b0;

    // plain ALU op and PC+4 op pass through in one cycle
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b00, 3'b010, 32'h00001234, 32'h0, 5'd3, 32'h44);
    #1;
    chk("alu_flag", misalign_o, 1'b0);
    chk("alu_stall", stall_o, 1'b0);
    chk("alu_req_valid", req_valid, 1'b0);
    @(negedge clk);
    chk("alu_regwrite", RegWriteW, 1'b1);
    chk("alu_result", ALUResultW, 32'h00001234);
    chk("alu_rd", RdW, 5'd3);
    drive(1'b1, 1'b0, 2'b10, 3'b000, 32'h0, 32'h0, 5'd1, 32'h88);
    @(negedge clk);
    chk("jal_resultsrc", ResultSrcW, 2'b10);
    chk("jal_pc4", PCPlus4W, 32'h88);

    // reset while in WAIT, then a stray response
    drive(1'b1, 1'b0, 2'b01, 3'b010, 32'h300, 32'h0, 5'd8, 32'h0);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    #1;
    chk("rw_in_wait", stall_o, 1'b1);
    reset = 1'b1;
    nop();
    #1;
    chk("rw_regwrite", RegWriteW, 1'b0);
    chk("rw_aluresult", ALUResultW, 32'h0);
    chk("rw_readdata", ReadDataW, 32'h0);
    chk("rw_stall", stall_o, 1'b0);
    @(negedge clk);
    reset     = 1'b0;
    rsp_valid = 1'b1;
    rsp_rdata = 32'hFFFFFFFF;
    #1;
    chk("stray_stall", stall_o, 1'b0);
    chk("stray_req_valid", req_valid, 1'b0);
    @(negedge clk);
    rsp_valid = 1'b0;
    chk("stray_readdata", ReadDataW, 32'h0);
    chk("stray_regwrite", RegWriteW, 1'b0);
    drive(1'b1, 1'b0, 2'b01, 3'b010, 32'h104, 32'h0, 5'd2, 32'h0);
    req_ready = 1'b1;
    #1;
    chk("post_rst_idle_issue", req_valid, 1'b1);
    @(negedge clk);
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_rdata = 32'h13572468;
    @(negedge clk);
    rsp_valid = 1'b0;
    chk("post_rst_readdata", ReadDataW, 32'h13572468);
    nop();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
